// File: rtl/writeback_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | writeback_arbiter: per-unit result queues, round-robin drained onto the |
// | single register-file write port, with per-thread flush and x0 drop.     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module writeback_arbiter #(
  parameter int NUM_UNITS  = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_UNITS-1:0]            unit_valid,
  output logic [NUM_UNITS-1:0]            unit_ready,
  input  logic [NUM_UNITS-1:0][1:0]       unit_thread,
  input  logic [NUM_UNITS-1:0][4:0]       unit_rd,
  input  logic [NUM_UNITS-1:0][XLEN-1:0]  unit_data,
  input  logic                            flush_valid,
  input  logic [1:0]                      flush_thread,
  output logic                            wr_en,
  output logic [4:0]                      rd_addr,
  output logic [XLEN-1:0]                 new_data,
  output logic [1:0]                      thread_rd_id,
  output logic                            busy
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_rr_w  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_rr_w:0]    c_units   = (c_rr_w + 1)'(NUM_UNITS);
  localparam logic [c_rr_w-1:0]  c_last    = c_rr_w'(NUM_UNITS - 1);

  logic [NUM_UNITS-1:0]            w_nonempty;
  logic [NUM_UNITS-1:0]            w_nonempty_nxt;
  logic [NUM_UNITS-1:0]            w_pop_vec;
  logic [NUM_UNITS-1:0]            w_head_kill;
  logic [NUM_UNITS-1:0][1:0]       w_head_thread;
  logic [NUM_UNITS-1:0][4:0]       w_head_rd;
  logic [NUM_UNITS-1:0][XLEN-1:0]  w_head_data;

  logic [c_rr_w-1:0]  r_rr;
  logic [c_rr_w-1:0]  w_grant;
  logic [c_rr_w:0]    w_idx;
  logic               w_pop;
  logic               w_sel_kill;
  logic               w_write;

  generate
    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
      logic [c_ptr_w-1:0]    r_head;
      logic [c_ptr_w-1:0]    r_tail;
      logic [c_cnt_w-1:0]    r_count;
      logic [c_cnt_w-1:0]    w_cnt_nxt;
      logic [FIFO_DEPTH-1:0] r_kill;
      logic [1:0]            r_thread [FIFO_DEPTH];
      logic [4:0]            r_rd     [FIFO_DEPTH];
      logic [XLEN-1:0]       r_data   [FIFO_DEPTH];
      logic                  w_push;
      logic                  w_pop_i;

      // Writes to x0 complete the handshake but never occupy a slot.
      assign unit_ready[i] = (r_count < c_depth);
      assign w_push        = unit_valid[i] && unit_ready[i] && (unit_rd[i] != 5'd0);
      assign w_pop_i       = w_pop_vec[i];

      always_comb begin
        w_cnt_nxt = r_count;
        if (w_push && !w_pop_i) begin
          w_cnt_nxt = r_count + c_cnt_one;
        end else if (!w_push && w_pop_i) begin
          w_cnt_nxt = r_count - c_cnt_one;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
          r_kill  <= '0;
        end else begin
          for (int e = 0; e < FIFO_DEPTH; e++) begin
            if (flush_valid && (r_thread[e] == flush_thread)) begin
              r_kill[e] <= 1'b1;
            end
          end
          if (w_push) begin
            r_kill[r_tail] <= flush_valid && (unit_thread[i] == flush_thread);
            r_tail         <= r_tail + c_ptr_one;
          end
          if (w_pop_i) begin
            r_head <= r_head + c_ptr_one;
          end
          r_count <= w_cnt_nxt;
        end
      end

      // Payload needs no reset: only slots covered by count are ever read out.
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_thread[r_tail] <= unit_thread[i];
          r_rd[r_tail]     <= unit_rd[i];
          r_data[r_tail]   <= unit_data[i];
        end
      end

      assign w_nonempty[i]     = (r_count != '0);
      assign w_nonempty_nxt[i] = (w_cnt_nxt != '0);
      assign w_head_kill[i]    = r_kill[r_head];
      assign w_head_thread[i]  = r_thread[r_head];
      assign w_head_rd[i]      = r_rd[r_head];
      assign w_head_data[i]    = r_data[r_head];
      assign w_pop_vec[i]      = w_pop && (w_grant == c_rr_w'(i));
    end
  endgenerate

  // First non-empty queue at or after the rr pointer, wrapping.
  always_comb begin
    w_pop   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      w_idx = {1'b0, r_rr} + (c_rr_w + 1)'(k);
      if (w_idx >= c_units) begin
        w_idx = w_idx - c_units;
      end
      if (!w_pop && w_nonempty[w_idx[c_rr_w-1:0]]) begin
        w_pop   = 1'b1;
        w_grant = w_idx[c_rr_w-1:0];
      end
    end
  end

  // A flush in the pop cycle must also suppress the entry leaving now.
  assign w_sel_kill = w_head_kill[w_grant] ||
                      (flush_valid && (w_head_thread[w_grant] == flush_thread));
  assign w_write    = w_pop && !w_sel_kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr         <= '0;
      wr_en        <= 1'b0;
      rd_addr      <= '0;
      new_data     <= '0;
      thread_rd_id <= '0;
      busy         <= 1'b0;
    end else begin
      wr_en <= w_write;
      busy  <= (|w_nonempty_nxt) | w_write;
      if (w_pop) begin
        rd_addr      <= w_head_rd[w_grant];
        new_data     <= w_head_data[w_grant];
        thread_rd_id <= w_head_thread[w_grant];
        r_rr         <= (w_grant == c_last) ? '0 : (w_grant + c_rr_w'(1));
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Collects completed results from NUM_UNITS execution units and serialises them onto the single register-file write port: wr_en, rd_addr, new_data, thread_rd_id.
- Each unit feeds a private FIFO_DEPTH-entry queue.
- A round-robin arbiter pops at most one entry per cycle into registered write-port outputs.
- Supports per-thread flush of queued results and drops writes to x0 at the input.

Parameters:
- NUM_UNITS, 3, number of producing execution units (ALU, MUL, LSU).
- FIFO_DEPTH, 2, entries per unit queue; power of two, >= 2.
- XLEN, cpu_config XLEN (32), data width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- unit_valid  input  NUM_UNITS  result valid, one bit per unit.
- unit_ready  output  NUM_UNITS  queue can accept, one bit per unit.
- unit_thread  input  NUM_UNITS x 2  thread id of the result.
- unit_rd  input  NUM_UNITS x 5 (rs_addr_t)  destination register.
- unit_data  input  NUM_UNITS x XLEN  result value.
- flush_valid  input  1  kill all queued results of one thread.
- flush_thread  input  2  thread to kill.
- wr_en  output  1  register-file write strobe.
- rd_addr  output  5 (rs_addr_t)  write address.
- new_data  output  XLEN  write data.
- thread_rd_id  output  2  write thread bank.
- busy  output  1  any queue non-empty or wr_en high.

Behaviour:
- Reset (async, rst=1):
  - All queues empty, all kill bits cleared, round-robin pointer = 0.
  - wr_en=0, rd_addr=0, new_data=0, thread_rd_id=0, busy=0.
  - unit_ready = all ones once rst deasserts.
  - Reset mid-operation discards all queued results; no write is emitted for them.
- Handshake:
  - Push on unit_valid[i] && unit_ready[i].
  - unit_ready[i] = (count[i] < FIFO_DEPTH), derived from registered count only. No same-cycle pop pass-through: a full queue stays not-ready in the cycle it is popped.
  - unit_valid[i] while ready low is ignored; the producer holds it.
- x0 filter: a push with unit_rd=0 is handshaken (ready honoured) but not enqueued.
- Flush:
  - On flush_valid, every queued entry with thread == flush_thread gets its kill bit set at the clock edge.
  - A push in the same cycle with matching thread is enqueued already killed.
  - A pop in the same cycle is checked against the flush: a matching popped entry produces wr_en=0.
- Arbitration (combinational, per cycle):
  - Candidates are the non-empty queues.
  - The winner is the first candidate searching from the rr pointer upward, modulo NUM_UNITS.
  - Exactly one pop per cycle when any candidate exists.
  - After a grant, the rr pointer = winner+1 (mod NUM_UNITS).
  - Killed entries compete and pop normally; this consumes the slot.
- Output register, loaded every edge:
  - wr_en = pop && !kill.
  - rd_addr, new_data, thread_rd_id = popped head fields when pop occurs; otherwise they hold their previous values.
- Latency:
  - A push at edge E0 into an empty queue with no contention gives wr_en high in the cycle after E1 (two edges).
  - Sustained throughput is one write per cycle aggregate.
- Ordering: results from one unit are written in arrival order. No ordering is guaranteed across units.
- Queue storage:
  - Circular buffer with wrapping head/tail pointers of log2(FIFO_DEPTH) bits plus a count.
  - Simultaneous push and pop keeps count unchanged and advances both pointers.
- busy = OR(count != 0) | wr_en, registered.

Test Plan:
- Single push: unit0 pushes {thread=2, rd=5, data=0xDEADBEEF} -> two edges later wr_en=1 for one cycle with rd_addr=5, thread_rd_id=2, new_data=0xDEADBEEF; busy falls the following cycle.
- x0 drop: unit1 pushes rd=0, data=0x1234 -> unit_ready stays 1, wr_en never asserts, busy stays 0.
- Round-robin: all three units push one result in the same cycle (rd=1,2,3) after reset -> wr_en on 3 consecutive cycles in order unit0, unit1, unit2. A second burst of three, with rr pointer at 0 again, gives the same order.
- Backpressure and wrap: hold unit2 valid for 6 pushes (rd=10..15) while units 0 and 1 stream continuously -> unit_ready[2] toggles low when count=2. All six writes appear in order rd=10..15. Pointers wrap without loss or duplication.
- Flush: queue thread 1 rd=7 and thread 3 rd=8 in unit0, then pulse flush_valid with flush_thread=1 before the pop -> only rd=8/thread 3 is written. The killed slot costs one cycle with wr_en=0.
- Async reset mid-burst: assert rst with 2 entries queued in each unit -> wr_en drops immediately without waiting for clk. After release, no stale write occurs, unit_ready = 3'b111, and busy=0.
